instr_encoder: RTL and testbench

- Streaming RV32I instruction encoder: takes decoded fields (format, opcode, registers, functs, signed immediate) and packs them into a 32-bit instruction word.
- Immediate bits are scattered into the I/S/B/U/J field layouts.
- Each output word carries an auto-incrementing instruction-memory address, for use by the program loader and by the self-check bench that feeds the decode path.
- Valid/ready on both sides; registered output stage plus a one-entry skid buffer.

---
 rtl/instr_encoder.sv | 141 ++++++++++++++
 tb/tb_instr_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : streaming RV32I field-to-word encoder with address tagging
// Revision      : 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic              err_sticky
);

   localparam logic [2:0]        FMT_R     = 3'd0;
   localparam logic [2:0]        FMT_I     = 3'd1;
   localparam logic [2:0]        FMT_S     = 3'd2;
   localparam logic [2:0]        FMT_B     = 3'd3;
   localparam logic [2:0]        FMT_U     = 3'd4;
   localparam logic [2:0]        FMT_J     = 3'd5;
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   logic [31:0] enc_instr;
   logic        enc_err;
   logic        in_xfer;
   logic        out_xfer;
   logic        load_out;
   logic        skid_full;
   logic        skid_full_nxt;
   logic [31:0] skid_instr;
   logic        skid_err;

   // Sign-extension checks: every bit above the field's top bit must match it.
   logic ext11_ok;
   logic ext12_ok;
   logic ext20_ok;

   assign ext11_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign ext12_ok = (&in_imm[31:12]) || !(|in_imm[31:12]);
   assign ext20_ok = (&in_imm[31:20]) || !(|in_imm[31:20]);

   always_comb begin
      enc_instr = '0;
      enc_err   = 1'b0;
      case (in_fmt)
         FMT_R: begin
            enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         end
         FMT_I: begin
            enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            enc_err   = !ext11_ok;
         end
         FMT_S: begin
            enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            enc_err   = !ext11_ok;
         end
         FMT_B: begin
            enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
            enc_err   = !ext12_ok || in_imm[0];
         end
         FMT_U: begin
            enc_instr = {in_imm[31:12], in_rd, in_opcode};
            enc_err   = |in_imm[11:0];
         end
         FMT_J: begin
            enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            enc_err   = !ext20_ok || in_imm[0];
         end
         default: begin
            enc_instr = '0;
            enc_err   = 1'b1;
         end
      endcase
   end

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign load_out = !out_valid || out_ready;

   // A loading output stage always drains the skid; a stalled one parks new input there.
   assign skid_full_nxt = load_out ? 1'b0 : (skid_full || in_xfer);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_instr  <= '0;
         out_err    <= 1'b0;
         out_addr   <= BASE_ADDR;
         err_sticky <= 1'b0;
         in_ready   <= 1'b1;
         skid_full  <= 1'b0;
         skid_instr <= '0;
         skid_err   <= 1'b0;
      end else begin
         if (load_out) begin
            if (skid_full) begin
               out_instr <= skid_instr;
               out_err   <= skid_err;
               out_valid <= 1'b1;
            end else if (in_xfer) begin
               out_instr <= enc_instr;
               out_err   <= enc_err;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (in_xfer) begin
            skid_instr <= enc_instr;
            skid_err   <= enc_err;
         end
         skid_full <= skid_full_nxt;
         in_ready  <= !skid_full_nxt;
         if (out_xfer) begin
            out_addr <= out_addr + ADDR_STEP;
            if (out_err) begin
               err_sticky <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodes, backpressure, async
// reset, streaming and randomized traffic against a behavioural model.
`default_nettype none

module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_err;
   logic        err_sticky;

   logic        w_in_ready, w_out_valid, w_out_err, w_err_sticky;
   logic [31:0] w_out_instr;
   logic [3:0]  w_out_addr;

   int total = 0;
   int bad   = 0;
   int n_out = 0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(fmt), .in_opcode(opcode), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2),
      .in_funct3(funct3), .in_funct7(funct7), .in_imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky)
   );

   instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h8)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_fmt(fmt), .in_opcode(opcode), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2),
      .in_funct3(funct3), .in_funct7(funct7), .in_imm(imm),
      .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
      .out_addr(w_out_addr), .out_err(w_out_err), .err_sticky(w_err_sticky)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: returns {err, instr} from the format rules and numeric ranges.
   function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                         input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] im);
      longint s;
      logic [31:0] w;
      logic e;
      s = longint'($signed(im));
      w = 32'h0;
      e = 1'b0;
      case (f)
         3'd0: w = {f7, s2, s1, f3, d, op};
         3'd1: begin
            w = {im[11:0], s1, f3, d, op};
            e = (s < -2048) || (s > 2047);
         end
         3'd2: begin
            w = {im[11:5], s2, s1, f3, im[4:0], op};
            e = (s < -2048) || (s > 2047);
         end
         3'd3: begin
            w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            e = (s < -4096) || (s > 4095) || (s % 2 != 0);
         end
         3'd4: begin
            w = {im[31:12], d, op};
            e = (longint'(im) % 4096) != 0;
         end
         3'd5: begin
            w = {im[20], im[10:1], im[11], im[19:12], d, op};
            e = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
         end
         default: begin
            w = 32'h0;
            e = 1'b1;
         end
      endcase
      return {e, w};
   endfunction

   logic [32:0] exp_q[$];
   logic [31:0] exp_addr;
   int          wrap_addr;
   logic        sticky_m;
   logic        held_v;
   logic [31:0] held_instr, held_addr;
   logic        held_err;

   always @(negedge clk) begin
      if (rst_n) begin
         logic [32:0] e;
         if (held_v) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_instr", out_instr, held_instr);
            check("stall_addr", out_addr, held_addr);
            check("stall_err", out_err, held_err);
         end
         held_v     = out_valid && !out_ready;
         held_instr = out_instr;
         held_addr  = out_addr;
         held_err   = out_err;
         check("sticky", err_sticky, sticky_m);
         if (out_valid && out_ready) begin
            check("spurious_out", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("instr", out_instr, e[31:0]);
               check("err", out_err, e[32]);
               check("addr", out_addr, exp_addr);
               check("wrap_addr", w_out_addr, wrap_addr);
               if (e[32]) sticky_m = 1'b1;
            end
            exp_addr  = exp_addr + 32'd4;
            wrap_addr = (wrap_addr + 4) % 16;
            n_out++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm));
         end
      end
   end

   task automatic set_f(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
      fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
   endtask

   task automatic rand_f(input bit legal);
      fmt    = legal ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
      opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      case ($urandom_range(0, 2))
         0: imm = $urandom;
         1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         default: imm = $urandom & 32'hFFFF_F000;
      endcase
   endtask

   task automatic send();
      int n;
      n = 0;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("send_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] ins, input logic e,
                             input logic [31:0] a);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_instr"}, out_instr, ins);
      check({tag, "_err"}, out_err, e);
      check({tag, "_addr"}, out_addr, a);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int base_out;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      set_f(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      exp_addr = 32'h0; wrap_addr = 8; sticky_m = 1'b0; held_v = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_instr", out_instr, 32'h0);
      check("rst_out_err", out_err, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_addr", out_addr, 32'h0);
      check("rst_wrap_addr", w_out_addr, 4'h8);
      check("rst_sticky", err_sticky, 1'b0);
      rst_n = 1'b1;

      // Directed encodes
      set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);            send();
      expect_out("addi", 32'h00500093, 1'b0, 32'd0);
      set_f(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);    send();
      expect_out("sw", 32'hFE21AE23, 1'b0, 32'd4);
      set_f(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8);    send();
      expect_out("beq", 32'hFE000CE3, 1'b0, 32'd8);
      set_f(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);          send();
      expect_out("jal", 32'h001000EF, 1'b0, 32'd12);
      set_f(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);     send();
      expect_out("lui", 32'h123452B7, 1'b0, 32'd16);
      set_f(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);    send();
      expect_out("add", 32'h002081B3, 1'b0, 32'd20);
      check("sticky_clear", err_sticky, 1'b0);

      // Range and format errors
      set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);         send();
      expect_out("i_range", 32'h80000093, 1'b1, 32'd24);
      check("sticky_set", err_sticky, 1'b1);
      set_f(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);            send();
      expect_out("b_odd", 32'h00000163, 1'b1, 32'd28);
      set_f(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);     send();
      expect_out("u_low", 32'h123452B7, 1'b1, 32'd32);
      set_f(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'd0);            send();
      expect_out("fmt7", 32'h0, 1'b1, 32'd36);

      // Async reset with two words buffered
      out_ready = 1'b0;
      rand_f(1'b1); send();
      rand_f(1'b1); send();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_addr", out_addr, 32'h0);
      check("arst_sticky", err_sticky, 1'b0);
      check("arst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      exp_addr = 32'h0; wrap_addr = 8; sticky_m = 1'b0; held_v = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Backpressure: three words offered into a stalled output
      base_out = n_out;
      set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5); send();
      rand_f(1'b1); send();
      rand_f(1'b1);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_hold_instr", out_instr, 32'h00500093);
         check("bp_hold_addr", out_addr, 32'h0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("bp_count", n_out - base_out, 3);
      check("bp_next_addr", out_addr, 32'd12);
      @(posedge clk);
      #1;

      // Streaming: eight back-to-back words
      base_out = n_out;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_f(1'b1);
         @(negedge clk);
         check("stream_in_ready", in_ready, 1'b1);
         if (i > 0) check("stream_out_valid", out_valid, 1'b1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("stream_last_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      check("stream_count", n_out - base_out, 8);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         rand_f(1'b0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while ((out_valid || exp_q.size() != 0) && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("drain_queue", exp_q.size(), 0);
      check("drain_valid", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
